// File: rtl/uart_rx_framed.sv
// Tick-enabled UART receiver: 8 data bits LSB first, optional parity,
// start-glitch filter, framing-error pulse and line-break hold-off.
module uart_rx_framed #(
  parameter int RX_OVERSAMPLE = 16,
  parameter bit PARITY_EN     = 1'b0,
  parameter bit PARITY_ODD    = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_Rx_ClkTick,
  input  logic       i_Rx_Data,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Done,
  output logic       o_Parity_Err,
  output logic       o_Frame_Err,
  output logic       o_Rx_Busy
);

  localparam int TW = $clog2(RX_OVERSAMPLE);
  localparam logic [TW-1:0] HALF = TW'(RX_OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(RX_OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic [TW-1:0]   tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            perr_q, perr_d;
  logic            done_q, done_d;
  logic            pout_q, pout_d;
  logic            ferr_q, ferr_d;
  logic            rx_s;
  logic            mid;

  assign rx_s = sync_q[1];
  assign mid  = (tick_q == FULL);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    perr_d  = perr_q;
    done_d  = 1'b0;
    pout_d  = 1'b0;
    ferr_d  = 1'b0;
    if (i_Rx_ClkTick) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d = S_START;
            tick_d  = '0;
          end
        end
        S_START: begin
          if (tick_q == HALF) begin
            tick_d  = '0;
            bit_d   = '0;
            perr_d  = 1'b0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_DATA: begin
          if (mid) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7)
              state_d = PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_PARITY: begin
          if (mid) begin
            tick_d  = '0;
            perr_d  = (^shift_q) ^ rx_s ^ PARITY_ODD;
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_STOP: begin
          if (mid) begin
            tick_d = '0;
            if (rx_s) begin
              byte_d  = shift_q;
              done_d  = 1'b1;
              pout_d  = perr_q;
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_BREAK: begin
          // a held-low line must go high before a new start is accepted
          if (rx_s) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sync_q  <= 2'b11;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      perr_q  <= 1'b0;
      done_q  <= 1'b0;
      pout_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], i_Rx_Data};
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      perr_q  <= perr_d;
      done_q  <= done_d;
      pout_q  <= pout_d;
      ferr_q  <= ferr_d;
    end
  end

  assign o_Rx_Byte    = byte_q;
  assign o_Rx_Done    = done_q;
  assign o_Parity_Err = pout_q;
  assign o_Frame_Err  = ferr_q;
  assign o_Rx_Busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: an 8N1 instance and an 8E1 instance,
// table vectors, corner sequences and random frames vs a frame model.
module tb_uart_rx_framed;

  localparam int BITCLK = 64;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick;
  logic       rx [2];
  logic [7:0] byte_o [2];
  logic       done_o [2];
  logic       perr_o [2];
  logic       ferr_o [2];
  logic       busy_o [2];

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] last [2];
  logic [10:0] evq0 [$];
  logic [10:0] evq1 [$];

  always #5 clk = ~clk;

  uart_rx_framed u_n (
    .clk(clk), .reset_n(reset_n), .i_Rx_ClkTick(tick),
    .i_Rx_Data(rx[0]), .o_Rx_Byte(byte_o[0]), .o_Rx_Done(done_o[0]),
    .o_Parity_Err(perr_o[0]), .o_Frame_Err(ferr_o[0]),
    .o_Rx_Busy(busy_o[0])
  );

  uart_rx_framed #(.RX_OVERSAMPLE(16), .PARITY_EN(1'b1),
                   .PARITY_ODD(1'b0)) u_p (
    .clk(clk), .reset_n(reset_n), .i_Rx_ClkTick(tick),
    .i_Rx_Data(rx[1]), .o_Rx_Byte(byte_o[1]), .o_Rx_Done(done_o[1]),
    .o_Parity_Err(perr_o[1]), .o_Frame_Err(ferr_o[1]),
    .o_Rx_Busy(busy_o[1])
  );

  initial begin
    int tc;
    tc = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tc = tc + 1;
      tick = (tc % 4 == 0);
    end
  end

  // every sampled cycle with a pulse becomes one event
  always @(negedge clk) begin
    if (done_o[0] || ferr_o[0] || perr_o[0])
      evq0.push_back({done_o[0], ferr_o[0], perr_o[0], byte_o[0]});
    if (done_o[1] || ferr_o[1] || perr_o[1])
      evq1.push_back({done_o[1], ferr_o[1], perr_o[1], byte_o[1]});
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total_cnt++;
    if (got !== exp)
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    else
      pass_cnt++;
  endtask

  task automatic send_bit(int d, logic b);
    rx[d] = b;
    repeat (BITCLK) @(negedge clk);
  endtask

  task automatic run_frame(int d, logic [7:0] data, logic pbit,
                           logic stop, logic idle);
    send_bit(d, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d, data[i]);
    if (d == 1) send_bit(d, pbit);
    send_bit(d, stop);
    if (!stop) begin
      repeat (3) send_bit(d, 1'b0);
      chk("break_busy", 32'(busy_o[d]), 32'd1);
      send_bit(d, 1'b1);
    end
    if (idle) begin
      send_bit(d, 1'b1);
      chk("idle_busy", 32'(busy_o[d]), 32'd0);
    end
  endtask

  task automatic expect_ev(string nm, int d, int n_exp,
                           logic [10:0] e0, logic [10:0] e1);
    int n;
    logic [10:0] got;
    n = (d == 0) ? evq0.size() : evq1.size();
    chk({nm, "_count"}, 32'(n), 32'(n_exp));
    for (int i = 0; i < n && i < n_exp; i++) begin
      got = (d == 0) ? evq0.pop_front() : evq1.pop_front();
      chk({nm, "_event"}, 32'(got), 32'(i == 0 ? e0 : e1));
    end
    evq0.delete();
    evq1.delete();
  endtask

  function automatic logic [10:0] model(int d, logic [7:0] data,
                                        logic pbit, logic stop);
    int ones;
    logic perr;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(data[i]);
    perr = (d == 1) && (((ones + int'(pbit)) % 2) != 0);
    if (stop) return {1'b1, 1'b0, perr, data};
    return {1'b0, 1'b1, 1'b0, last[d]};
  endfunction

  typedef struct {
    int         d;
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    logic       e_done;
    logic       e_ferr;
    logic       e_perr;
    logic [7:0] e_byte;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [10:0] e;
    tbl[0] = '{0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[1] = '{0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
    tbl[2] = '{0, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A};
    tbl[3] = '{1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h07};
    tbl[4] = '{1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h07};
    tbl[5] = '{1, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h07};

    reset_n = 1'b0;
    rx[0] = 1'b1;
    rx[1] = 1'b1;
    repeat (5) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_byte", 32'(byte_o[d]), 32'h0);
      chk("rst_pulses", 32'({done_o[d], perr_o[d], ferr_o[d]}), 32'h0);
      chk("rst_busy", 32'(busy_o[d]), 32'h0);
    end
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    last[0] = 8'h00;
    last[1] = 8'h00;

    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].d, tbl[i].data, tbl[i].pbit, tbl[i].stop, 1'b1);
      expect_ev($sformatf("tbl%0d", i), tbl[i].d, 1,
                {tbl[i].e_done, tbl[i].e_ferr, tbl[i].e_perr,
                 tbl[i].e_byte}, 11'h0);
      chk($sformatf("tbl%0d_byte", i), 32'(byte_o[tbl[i].d]),
          32'(tbl[i].e_byte));
      if (tbl[i].e_done) last[tbl[i].d] = tbl[i].e_byte;
    end

    // start glitch: 4 ticks low
    rx[0] = 1'b0;
    repeat (16) @(negedge clk);
    rx[0] = 1'b1;
    repeat (2 * BITCLK) @(negedge clk);
    chk("glitch_busy", 32'(busy_o[0]), 32'd0);
    expect_ev("glitch", 0, 0, 11'h0, 11'h0);
    run_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1);
    expect_ev("post_glitch", 0, 1, {3'b100, 8'h5A}, 11'h0);

    // reset after third data bit of 0xFF
    send_bit(0, 1'b0);
    repeat (3) send_bit(0, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("midrst_byte", 32'(byte_o[0]), 32'h0);
    chk("midrst_busy", 32'(busy_o[0]), 32'h0);
    chk("midrst_byte_p", 32'(byte_o[1]), 32'h0);
    repeat (8) send_bit(0, 1'b1);
    expect_ev("midrst", 0, 0, 11'h0, 11'h0);
    last[0] = 8'h00;
    last[1] = 8'h00;
    run_frame(0, 8'h81, 1'b0, 1'b1, 1'b1);
    expect_ev("post_rst", 0, 1, {3'b100, 8'h81}, 11'h0);

    // back-to-back frames, no idle bit between them
    run_frame(0, 8'h00, 1'b0, 1'b1, 1'b0);
    run_frame(0, 8'hFF, 1'b0, 1'b1, 1'b1);
    expect_ev("b2b", 0, 2, {3'b100, 8'h00}, {3'b100, 8'hFF});
    last[0] = 8'hFF;

    for (int i = 0; i < 20; i++) begin
      int d;
      logic [7:0] data;
      logic pbit, stop;
      d    = int'($urandom_range(0, 1));
      data = 8'($urandom);
      pbit = 1'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      e    = model(d, data, pbit, stop);
      run_frame(d, data, pbit, stop, 1'b1);
      expect_ev($sformatf("rnd%0d", i), d, 1, e, 11'h0);
      if (stop) last[d] = data;
      chk($sformatf("rnd%0d_byte", i), 32'(byte_o[d]), 32'(last[d]));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_framed.md
Name: uart_rx_framed

Overview:
Single-clock UART receiver that runs on the system clock and advances only on the oversample tick enable (o_Rx_ClkTick) from baudRateGenerator. It receives 8N1 or 8E1/8O1 frames, LSB first, with mid-bit sampling. It adds a start-bit glitch filter, framing-error detection, optional parity check and break handling. It is the receive counterpart to uart_tx_controller for designs where the whole datapath stays in the system clock domain.

Parameters:
RX_OVERSAMPLE, 16, ticks per bit; must be even and ≥4.
PARITY_EN, 0, 1 = a parity bit follows the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.

Ports:
clk  input  1  system clock.
reset_n  input  1  synchronous, active-low reset.
i_Rx_ClkTick  input  1  oversample tick enable, one clk cycle wide, RX_OVERSAMPLE ticks per bit.
i_Rx_Data  input  1  asynchronous serial line; idle is high.
o_Rx_Byte  output  8  last received byte.
o_Rx_Done  output  1  one-clk pulse when a byte is accepted.
o_Parity_Err  output  1  one-clk pulse, coincident with o_Rx_Done.
o_Frame_Err  output  1  one-clk pulse when the stop bit samples 0.
o_Rx_Busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (clk edge with reset_n=0):
  - state = IDLE.
  - All outputs = 0 and o_Rx_Byte = 8'h00.
  - Both synchronizer flops = 1.
  - Tick counter and bit counter = 0.
  - Reset mid-frame abandons the frame and raises no pulse.
- Synchronizer: i_Rx_Data passes through 2 flops. All sampling uses the second flop (rx_s).
- State and counter updates happen only on clk cycles where i_Rx_ClkTick=1. Exception: the output pulses clear on the next clk cycle regardless of tick.
- IDLE: on a tick with rx_s=0, go to START with tick_cnt=0.
- START: tick_cnt increments on each tick. At tick_cnt = RX_OVERSAMPLE/2-1 (mid start bit):
  - If rx_s=0: go to DATA, tick_cnt=0, bit_cnt=0.
  - If rx_s=1: treat as a glitch and return to IDLE with no pulse.
- DATA: on each tick where tick_cnt = RX_OVERSAMPLE-1:
  - Shift rx_s into the shift register at bit 7, shifting right (LSB first); reset tick_cnt.
  - After the 8th bit, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: sample at mid-bit using the same count rule. Parity is computed as XOR of the 8 data bits, XOR the parity bit, XOR PARITY_ODD. A nonzero result is a parity error, which is held internally until STOP.
- STOP: sample at mid-bit using the same count rule.
  - rx_s=1:
    - o_Rx_Byte = shift register.
    - o_Rx_Done = 1 for one clk cycle.
    - o_Parity_Err = held error flag (0 when PARITY_EN=0).
    - Return to IDLE at mid stop bit, so the next start edge is caught with no idle gap.
  - rx_s=0:
    - o_Frame_Err = 1 for one clk cycle.
    - o_Rx_Byte and o_Rx_Done unchanged.
    - Go to BREAK.
- BREAK: stay until a tick with rx_s=1, then go to IDLE. A line held low never re-triggers reception.
- Latency: o_Rx_Done rises on the clk edge that follows the tick at mid stop bit. That is 9.5 bit times (8N1) or 10.5 bit times (with parity) after the start edge, plus 2 clk cycles of synchronizer delay.
- o_Rx_Byte is stable from the o_Rx_Done pulse until the next o_Rx_Done pulse.
- o_Rx_Busy = 1 in START, DATA, PARITY, STOP and BREAK.

Test Plan (RX_OVERSAMPLE=16, one tick every 4 clks, 1 bit = 64 clks):
1. Reset, then send 8N1 frame 0xA5 → exactly one o_Rx_Done pulse of 1 clk; o_Rx_Byte=0xA5; o_Frame_Err=0; o_Rx_Busy returns to 0.
2. Drive the line low for 4 ticks, then high → no o_Rx_Done and no o_Frame_Err; state back in IDLE. A following 0x5A frame is received as 0x5A.
3. Send 0x3C with stop bit=0, hold the line low for 3 bit times, then release → one o_Frame_Err pulse; o_Rx_Byte still 0xA5; no o_Rx_Done. Busy stays high until the line returns high.
4. PARITY_EN=1, PARITY_ODD=0:
   - 0x07 with parity bit 1 → o_Rx_Done with o_Parity_Err=0.
   - 0x07 with parity bit 0 → o_Rx_Done with o_Parity_Err=1 in the same cycle; o_Rx_Byte=0x07.
5. Assert reset_n=0 for 1 clk after the 3rd data bit of 0xFF → all outputs 0 and o_Rx_Byte=0x00. A following 0x81 frame is received as 0x81.
6. Send 0x00 and 0xFF back-to-back with no idle bit between frames → two o_Rx_Done pulses with bytes 0x00 then 0xFF; no errors.
